// File: rtl/execute_mc_if.sv
`default_nettype none
// ============================================================================
// Module      : execute_mc_if
// Description : Operation / result bundle between the issue stage and the
//               execute unit.
//   master : issue side  - drives operation, operands, forwarding controls
//   slave  : execute_mc  - returns ready, data2_fwd, result and flags
// Revision    : 1.0 - initial release
// ============================================================================
interface execute_mc_if #(
  parameter int WIDTH = 24
);
  logic             valid_in;
  logic             ready_out;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [WIDTH-1:0] data3;
  logic [WIDTH-1:0] forward_m;
  logic [WIDTH-1:0] forward_wb;
  logic [1:0]       fwd_sel_a;
  logic [1:0]       fwd_sel_b;
  logic             alu_src;
  logic [3:0]       alu_control;
  logic             flags_we;
  logic [WIDTH-1:0] data2_fwd;
  logic             valid_out;
  logic [WIDTH-1:0] alu_result;
  logic             n;
  logic             z;
  logic             v;
  logic             c;

  modport master (
    output valid_in, data1, data2, data3, forward_m, forward_wb,
           fwd_sel_a, fwd_sel_b, alu_src, alu_control, flags_we,
    input  ready_out, data2_fwd, valid_out, alu_result, n, z, v, c
  );

  modport slave (
    input  valid_in, data1, data2, data3, forward_m, forward_wb,
           fwd_sel_a, fwd_sel_b, alu_src, alu_control, flags_we,
    output ready_out, data2_fwd, valid_out, alu_result, n, z, v, c
  );
endinterface
`default_nettype wire

// File: rtl/execute_mc.sv
`default_nettype none
// ============================================================================
// Module      : execute_mc
// Description : Execute stage with operand forwarding, single-cycle ALU and
//               an optional multi-cycle shift-add multiplier.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : execute_mc_if.slave (operation in, result/flags/ready out)
// Option      : define EXECUTE_MC_MUL_EN to enable opcode 8 (MUL); when
//               undefined opcode 8 is reserved and ready_out is always 1.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_mc #(
  parameter int WIDTH         = 24,
  parameter bit FWD_RSVD_ZERO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  execute_mc_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_PSB = 4'd7;

  function automatic logic [WIDTH-1:0] fwd_mux(input logic [1:0]       sel,
                                               input logic [WIDTH-1:0] reg_val,
                                               input logic [WIDTH-1:0] fwd_wb,
                                               input logic [WIDTH-1:0] fwd_m);
    case (sel)
      2'd0:    fwd_mux = reg_val;
      2'd1:    fwd_mux = fwd_wb;
      2'd2:    fwd_mux = fwd_m;
      default: fwd_mux = FWD_RSVD_ZERO ? '0 : reg_val;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Operand selection and single-cycle ALU
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] b_fwd;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   shamt;
  logic [31:0]      shamt_ext;
  logic             shift_oob;
  logic [WIDTH-1:0] alu_res;
  logic             res_v;
  logic             res_c;

  assign b_fwd         = fwd_mux(bus.fwd_sel_b, bus.data2, bus.forward_wb, bus.forward_m);
  assign bus.data2_fwd = b_fwd;
  assign op_a          = fwd_mux(bus.fwd_sel_a, bus.data1, bus.forward_wb, bus.forward_m);
  assign op_b          = bus.alu_src ? bus.data3 : b_fwd;

  assign sum       = {1'b0, op_a} + {1'b0, op_b};
  assign diff      = {1'b0, op_a} - {1'b0, op_b};
  assign shamt     = op_b[SHW-1:0];
  assign shamt_ext = 32'(shamt);
  // Only reachable when WIDTH is not a power of two.
  assign shift_oob = (shamt_ext >= 32'(WIDTH));

  always_comb begin
    alu_res = '0;
    res_v   = 1'b0;
    res_c   = 1'b0;
    case (bus.alu_control)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        res_c   = sum[WIDTH];
        res_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        res_c   = ~diff[WIDTH];  // carry = NOT borrow
        res_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SHL:  alu_res = shift_oob ? '0 : (op_a << shamt);
      OP_SHR:  alu_res = shift_oob ? '0 : (op_a >> shamt);
      OP_PSB:  alu_res = op_b;
      // Reserved opcodes (and MUL, whose result comes from the accumulator).
      default: alu_res = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Control and multiplier state
  // --------------------------------------------------------------------------
  logic             accept;
  logic             is_mul;
  logic             ready;

  logic [WIDTH-1:0] alu_result_q, alu_result_d;
  logic             valid_out_q,  valid_out_d;
  logic             n_q, n_d, z_q, z_d, v_q, v_d, c_q, c_d;

`ifdef EXECUTE_MC_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [SHW-1:0]   cnt_q,    cnt_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             mul_fwe_q, mul_fwe_d;
  logic [WIDTH-1:0] acc_step;

  assign ready    = (state_q == S_IDLE);
  assign is_mul   = (bus.alu_control == OP_MUL);
  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`else
  assign ready  = 1'b1;
  assign is_mul = 1'b0;
`endif

  assign accept        = bus.valid_in && ready;
  assign bus.ready_out = ready;

  always_comb begin
    alu_result_d = alu_result_q;
    valid_out_d  = 1'b0;
    n_d          = n_q;
    z_d          = z_q;
    v_d          = v_q;
    c_d          = c_q;
`ifdef EXECUTE_MC_MUL_EN
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    mul_fwe_d    = mul_fwe_q;
`endif

    if (accept && !is_mul) begin
      valid_out_d  = 1'b1;
      alu_result_d = alu_res;
      if (bus.flags_we) begin
        n_d = alu_res[WIDTH-1];
        z_d = (alu_res == '0);
        v_d = res_v;
        c_d = res_c;
      end
    end

`ifdef EXECUTE_MC_MUL_EN
    case (state_q)
      S_IDLE: begin
        if (accept && is_mul) begin
          state_d   = S_MUL;
          cnt_d     = SHW'(WIDTH - 1);
          acc_d     = '0;
          mcand_d   = op_a;
          mplier_d  = op_b;
          mul_fwe_d = bus.flags_we;
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q == '0) begin
          // Last bit consumed: result and pulse are registered together
          // with the move to DONE, so they are visible during DONE.
          state_d      = S_DONE;
          valid_out_d  = 1'b1;
          alu_result_d = acc_step;
          if (mul_fwe_q) begin
            n_d = acc_step[WIDTH-1];
            z_d = (acc_step == '0);
            v_d = 1'b0;
            c_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_q <= '0;
      valid_out_q  <= 1'b0;
      n_q          <= 1'b0;
      z_q          <= 1'b0;
      v_q          <= 1'b0;
      c_q          <= 1'b0;
`ifdef EXECUTE_MC_MUL_EN
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      mul_fwe_q    <= 1'b0;
`endif
    end else begin
      alu_result_q <= alu_result_d;
      valid_out_q  <= valid_out_d;
      n_q          <= n_d;
      z_q          <= z_d;
      v_q          <= v_d;
      c_q          <= c_d;
`ifdef EXECUTE_MC_MUL_EN
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      mul_fwe_q    <= mul_fwe_d;
`endif
    end
  end

  assign bus.alu_result = alu_result_q;
  assign bus.valid_out  = valid_out_q;
  assign bus.n          = n_q;
  assign bus.z          = z_q;
  assign bus.v          = v_q;
  assign bus.c          = c_q;

endmodule
`default_nettype wire

// File: tb/tb_execute_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_execute_mc
// Description : Self-checking bench for execute_mc: directed scenarios plus
//               randomized operations against an arithmetic reference model.
//               Follows EXECUTE_MC_MUL_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_mc;
  localparam int          W    = 24;
  localparam int          SHW  = $clog2(W);
  localparam logic [63:0] MASK = (64'd1 << W) - 64'd1;
  localparam longint      HALF = longint'(1) << (W - 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  execute_mc_if #(.WIDTH(W)) bus ();

  execute_mc #(.WIDTH(W), .FWD_RSVD_ZERO(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference flag register and last result
  logic        m_n = 1'b0, m_z = 1'b0, m_v = 1'b0, m_c = 1'b0;
  logic [63:0] m_res = 64'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_n"}, 64'(bus.n), 64'(m_n));
    check({tag, "_z"}, 64'(bus.z), 64'(m_z));
    check({tag, "_v"}, 64'(bus.v), 64'(m_v));
    check({tag, "_c"}, 64'(bus.c), 64'(m_c));
  endtask

  function automatic longint sval(input logic [63:0] x);
    if (x >= 64'(HALF)) return longint'(x) - 2 * HALF;
    return longint'(x);
  endfunction

  function automatic logic [63:0] fwd(input logic [1:0] sel, input logic [63:0] r,
                                      input logic [63:0] wb, input logic [63:0] m);
    case (sel)
      2'd1:    return wb;
      2'd2:    return m;
      default: return r;  // 0 = register; 3 = register when FWD_RSVD_ZERO=0
    endcase
  endfunction

  function automatic bit mul_enabled();
`ifdef EXECUTE_MC_MUL_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Reference ALU: plain integer arithmetic on the architectural rules.
  task automatic model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic fwe, output logic [63:0] res);
    longint s;
    logic   cf, vf;
    cf = 1'b0;
    vf = 1'b0;
    case (op)
      4'd0: begin
        res = (a + b) & MASK;
        cf  = (a + b) > MASK;
        s   = sval(a) + sval(b);
        vf  = (s >= HALF) || (s < -HALF);
      end
      4'd1: begin
        res = (a - b) & MASK;
        cf  = (a >= b);
        s   = sval(a) - sval(b);
        vf  = (s >= HALF) || (s < -HALF);
      end
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = a ^ b;
      4'd5: res = ((b % (64'd1 << SHW)) >= W) ? 64'd0 : ((a << (b % (64'd1 << SHW))) & MASK);
      4'd6: res = ((b % (64'd1 << SHW)) >= W) ? 64'd0 : (a >> (b % (64'd1 << SHW)));
      4'd7: res = b;
      4'd8: res = mul_enabled() ? ((a * b) & MASK) : 64'd0;
      default: res = 64'd0;
    endcase
    if (fwe) begin
      m_n = (res >= 64'(HALF));
      m_z = (res == 64'd0);
      m_v = vf;
      m_c = cf;
    end
    m_res = res;
  endtask

  task automatic drive(input logic [3:0] op, input logic [W-1:0] d1, input logic [W-1:0] d2,
                       input logic [W-1:0] d3, input logic [W-1:0] fm, input logic [W-1:0] fwb,
                       input logic [1:0] sa, input logic [1:0] sb, input logic src, input logic fwe);
    bus.valid_in    = 1'b1;
    bus.alu_control = op;
    bus.data1       = d1;
    bus.data2       = d2;
    bus.data3       = d3;
    bus.forward_m   = fm;
    bus.forward_wb  = fwb;
    bus.fwd_sel_a   = sa;
    bus.fwd_sel_b   = sb;
    bus.alu_src     = src;
    bus.flags_we    = fwe;
  endtask

  task automatic drive_garbage();
    drive(4'($urandom_range(0, 7)), W'($urandom), W'($urandom), W'($urandom),
          W'($urandom), W'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 1'b1);
  endtask

  // Present one operation and check its complete response.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] d1, input logic [W-1:0] d2,
                       input logic [W-1:0] d3, input logic [W-1:0] fm, input logic [W-1:0] fwb,
                       input logic [1:0] sa, input logic [1:0] sb, input logic src, input logic fwe);
    logic [63:0] a, bf, b, res;
    a  = fwd(sa, 64'(d1), 64'(fwb), 64'(fm));
    bf = fwd(sb, 64'(d2), 64'(fwb), 64'(fm));
    b  = src ? 64'(d3) : bf;
    drive(op, d1, d2, d3, fm, fwb, sa, sb, src, fwe);
    #1;
    check("data2_fwd", 64'(bus.data2_fwd), bf);
    model(op, a, b, fwe, res);
    @(posedge clk);
    #1;
    if (!(mul_enabled() && op == 4'd8)) begin
      check("valid_out", 64'(bus.valid_out), 64'd1);
      check("result", 64'(bus.alu_result), res);
      check("ready_after_op", 64'(bus.ready_out), 64'd1);
      check_flags("flags");
    end else begin
      check("mul_busy_ready", 64'(bus.ready_out), 64'd0);
      check("mul_busy_valid", 64'(bus.valid_out), 64'd0);
      for (int k = 2; k <= W; k++) begin
        drive_garbage();
        @(posedge clk);
        #1;
        check("mul_busy_ready", 64'(bus.ready_out), 64'd0);
        check("mul_busy_valid", 64'(bus.valid_out), 64'd0);
      end
      drive_garbage();
      @(posedge clk);
      #1;
      check("mul_valid", 64'(bus.valid_out), 64'd1);
      check("mul_result", 64'(bus.alu_result), res);
      check_flags("mul_flags");
      bus.valid_in = 1'b0;
      @(posedge clk);
      #1;
      check("mul_pulse_end", 64'(bus.valid_out), 64'd0);
      check("mul_ready_back", 64'(bus.ready_out), 64'd1);
    end
  endtask

  task automatic idle_cycle();
    bus.valid_in = 1'b0;
    bus.data2    = W'($urandom);
    @(posedge clk);
    #1;
    check("idle_valid", 64'(bus.valid_out), 64'd0);
    check("idle_result_hold", 64'(bus.alu_result), m_res);
    check_flags("idle_flags");
  endtask

  initial begin
    drive(4'd0, '0, '0, '0, '0, '0, 2'd0, 2'd0, 1'b0, 1'b0);
    bus.valid_in = 1'b0;

    // Reset state
    #12;
    check("rst_result", 64'(bus.alu_result), 64'd0);
    check("rst_valid", 64'(bus.valid_out), 64'd0);
    check_flags("rst_flags");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_ready", 64'(bus.ready_out), 64'd1);

    // ADD overflow into sign bit
    issue(4'd0, 24'h7FFFFF, 24'h000001, 24'h0, 24'h0, 24'h0, 2'd0, 2'd0, 1'b0, 1'b1);
    check("add_const", 64'(bus.alu_result), 64'h800000);
    check("add_v_const", 64'({bus.n, bus.z, bus.v, bus.c}), 64'b1010);

    // SUB with A taken from the memory-stage forward
    issue(4'd1, 24'd9, 24'd5, 24'h0, 24'd5, 24'd0, 2'd2, 2'd0, 1'b0, 1'b1);
    check("sub_const", 64'({bus.z, bus.c}), 64'b11);

    // Back-to-back ADD / XOR (no flags) / SHL by 30
    issue(4'd0, 24'h000100, 24'h000200, 24'h0, 24'h0, 24'h0, 2'd0, 2'd0, 1'b0, 1'b1);
    issue(4'd4, 24'hF0F0F0, 24'hFFFFFF, 24'h0, 24'h0, 24'h0, 2'd0, 2'd0, 1'b0, 1'b0);
    check("xor_keeps_add_flags", 64'({bus.n, bus.z, bus.v, bus.c}), 64'b0000);
    issue(4'd5, 24'h000001, 24'd30, 24'h0, 24'h0, 24'h0, 2'd0, 2'd0, 1'b0, 1'b0);
    check("shl30_const", 64'(bus.alu_result), 64'd0);

    // Forward-select coverage on B, immediate source, reserved opcode
    issue(4'd7, 24'h1, 24'h2, 24'h3, 24'hAAAAAA, 24'h555555, 2'd3, 2'd1, 1'b0, 1'b1);
    issue(4'd7, 24'h1, 24'h2, 24'h3, 24'hAAAAAA, 24'h555555, 2'd1, 2'd3, 1'b0, 1'b1);
    issue(4'd6, 24'h800000, 24'h2, 24'd23, 24'h0, 24'h0, 2'd0, 2'd2, 1'b1, 1'b1);
    issue(4'd12, 24'hFFFFFF, 24'hFFFFFF, 24'h0, 24'h0, 24'h0, 2'd0, 2'd0, 1'b0, 1'b1);
    idle_cycle();

    // Opcode 8: multiply when enabled, reserved otherwise
    issue(4'd8, 24'h000123, 24'h000010, 24'h0, 24'h0, 24'h0, 2'd0, 2'd0, 1'b0, 1'b1);
    check("op8_const", 64'(bus.alu_result), mul_enabled() ? 64'h001230 : 64'd0);
    idle_cycle();
    check("op8_ready", 64'(bus.ready_out), 64'd1);

`ifdef EXECUTE_MC_MUL_EN
    // Reset part-way through a multiply aborts it
    begin
      logic seen_valid;
      drive(4'd8, 24'h000123, 24'h000010, 24'h0, 24'h0, 24'h0, 2'd0, 2'd0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      bus.valid_in = 1'b0;
      repeat (9) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_result", 64'(bus.alu_result), 64'd0);
      check("abort_valid", 64'(bus.valid_out), 64'd0);
      m_n = 1'b0; m_z = 1'b0; m_v = 1'b0; m_c = 1'b0; m_res = 64'd0;
      check_flags("abort_flags");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("abort_ready", 64'(bus.ready_out), 64'd1);
      seen_valid = 1'b0;
      for (int k = 0; k < W + 4; k++) begin
        @(posedge clk);
        #1;
        if (bus.valid_out !== 1'b0) seen_valid = 1'b1;
      end
      check("abort_no_valid", 64'(seen_valid), 64'd0);
    end
`endif

    // Randomized operations, idles interleaved
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle_cycle();
      end else begin
        issue(4'($urandom_range(0, 15)), W'($urandom), W'($urandom),
              ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 31)) : W'($urandom),
              W'($urandom), W'($urandom), 2'($urandom), 2'($urandom),
              1'($urandom), 1'($urandom));
      end
    end

    bus.valid_in = 1'b0;
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
